// File: rtl/fsk_bit_demod_if.sv
// fsk_bit_demod_if: result bundle of the FSK bit demodulator.
// master drives data_o, data_valid_o, period_count_o, carrier_o, overflow_o; slave observes.
interface fsk_bit_demod_if #(
    parameter int COUNT_WIDTH = 16
);
    logic                   data_o;
    logic                   data_valid_o;
    logic [COUNT_WIDTH-1:0] period_count_o;
    logic                   carrier_o;
    logic                   overflow_o;

    modport master (
        output data_o,
        output data_valid_o,
        output period_count_o,
        output carrier_o,
        output overflow_o
    );

    modport slave (
        input data_o,
        input data_valid_o,
        input period_count_o,
        input carrier_o,
        input overflow_o
    );
endinterface

// File: rtl/fsk_bit_demod.sv
// fsk_bit_demod: two-tone FSK demodulator; counts clk cycles over a gate of carrier periods,
// slices with hysteresis + confirm filter. Ports: clk, reset (async high), rf_i (async carrier),
// out_if (master): data_o, data_valid_o strobe, period_count_o, carrier_o, sticky overflow_o.
module fsk_bit_demod #(
    parameter int SYNC_STAGES      = 2,
    parameter int PERIODS_PER_GATE = 16,
    parameter int COUNT_WIDTH      = 16,
    parameter int THRESHOLD        = 640,
    parameter int HYSTERESIS       = 4,
    parameter int CONFIRM          = 2,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rf_i,
    fsk_bit_demod_if.master out_if
);
    localparam int EW = $clog2(PERIODS_PER_GATE + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = $clog2(CONFIRM + 1);
    localparam int XW = COUNT_WIDTH + 1;

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [XW-1:0]          HI_TH     = XW'(THRESHOLD + HYSTERESIS);
    localparam logic [XW-1:0]          LO_TH     = XW'(THRESHOLD - HYSTERESIS);
    localparam logic [EW-1:0]          LAST_EDGE = EW'(PERIODS_PER_GATE - 1);
    localparam logic [IW-1:0]          IDLE_MAX  = IW'(TIMEOUT_CYCLES);
    localparam logic [IW-1:0]          IDLE_TRIP = IW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]          CONF_LAST = CW'(CONFIRM - 1);

    typedef enum logic {ACQUIRE, MEASURE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [COUNT_WIDTH-1:0] cyc_q, cyc_d;
    logic [EW-1:0]          edge_q, edge_d;
    logic [IW-1:0]          idle_q, idle_d;
    logic [CW-1:0]          conf_q, conf_d;
    logic                   data_q, data_d;
    logic                   dv_q, dv_d;
    logic [COUNT_WIDTH-1:0] period_q, period_d;
    logic                   carrier_q, carrier_d;
    logic                   ovf_q, ovf_d;

    logic                   edge_det;
    logic                   timeout;
    logic [COUNT_WIDTH-1:0] cyc_inc;
    logic [XW-1:0]          cnt_x;
    logic                   cand;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], rf_i};
        prev_d    = sync_q[SYNC_STAGES-1];
        edge_det  = sync_q[SYNC_STAGES-1] & ~prev_q;
        state_d   = state_q;
        cyc_d     = cyc_q;
        edge_d    = edge_q;
        conf_d    = conf_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        period_d  = period_q;
        carrier_d = carrier_q;
        ovf_d     = ovf_q;

        // Cycle count including the current cycle, pinned at all-ones.
        cyc_inc = (cyc_q == CNT_MAX) ? CNT_MAX : cyc_q + COUNT_WIDTH'(1);
        cnt_x   = {1'b0, cyc_inc};

        // Dead band keeps the current symbol.
        if (cnt_x >= HI_TH) begin
            cand = 1'b1;
        end else if (cnt_x <= LO_TH) begin
            cand = 1'b0;
        end else begin
            cand = data_q;
        end

        // Idle counter parks at TIMEOUT_CYCLES so the timeout fires once.
        if (edge_det) begin
            idle_d = '0;
        end else if (idle_q == IDLE_MAX) begin
            idle_d = idle_q;
        end else begin
            idle_d = idle_q + IW'(1);
        end
        timeout = !edge_det && (idle_q == IDLE_TRIP);

        unique case (state_q)
            ACQUIRE: begin
                if (edge_det) begin
                    cyc_d   = '0;
                    edge_d  = '0;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                cyc_d = cyc_inc;
                if (cyc_inc == CNT_MAX) begin
                    ovf_d = 1'b1;
                end
                if (edge_det) begin
                    if (edge_q == LAST_EDGE) begin
                        // Closing edge also opens the next gate.
                        period_d  = cyc_inc;
                        dv_d      = 1'b1;
                        carrier_d = 1'b1;
                        cyc_d     = '0;
                        edge_d    = '0;
                        if (cand != data_q) begin
                            if (conf_q == CONF_LAST) begin
                                data_d = cand;
                                conf_d = '0;
                            end else begin
                                conf_d = conf_q + CW'(1);
                            end
                        end else begin
                            conf_d = '0;
                        end
                    end else begin
                        edge_d = edge_q + EW'(1);
                    end
                end
            end
            default: state_d = ACQUIRE;
        endcase

        if (timeout) begin
            state_d   = ACQUIRE;
            carrier_d = 1'b0;
            conf_d    = '0;
            cyc_d     = '0;
            edge_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ACQUIRE;
            sync_q    <= '0;
            prev_q    <= 1'b0;
            cyc_q     <= '0;
            edge_q    <= '0;
            idle_q    <= '0;
            conf_q    <= '0;
            data_q    <= 1'b0;
            dv_q      <= 1'b0;
            period_q  <= '0;
            carrier_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            cyc_q     <= cyc_d;
            edge_q    <= edge_d;
            idle_q    <= idle_d;
            conf_q    <= conf_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            period_q  <= period_d;
            carrier_q <= carrier_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_if.data_o         = data_q;
    assign out_if.data_valid_o   = dv_q;
    assign out_if.period_count_o = period_q;
    assign out_if.carrier_o      = carrier_q;
    assign out_if.overflow_o     = ovf_q;
endmodule

// File: tb/tb_fsk_bit_demod.sv
// tb_fsk_bit_demod: directed bench for fsk_bit_demod with ideal square-wave carriers.
// A second instance (10-bit counter, 32-period gate) exercises counter saturation.
module tb_fsk_bit_demod;
    timeunit 1ns;
    timeprecision 1ps;

    logic clk = 1'b0;
    logic reset;
    logic rf_i;

    int nvec = 0;
    int nerr = 0;
    int step = 0;
    int per = 0;
    int ph = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int last = 0;

    fsk_bit_demod_if #(.COUNT_WIDTH(16)) bus ();
    fsk_bit_demod_if #(.COUNT_WIDTH(10)) ovb ();

    fsk_bit_demod u_dut (
        .clk    (clk),
        .reset  (reset),
        .rf_i   (rf_i),
        .out_if (bus)
    );

    fsk_bit_demod #(
        .COUNT_WIDTH      (10),
        .PERIODS_PER_GATE (32)
    ) u_ov (
        .clk    (clk),
        .reset  (reset),
        .rf_i   (rf_i),
        .out_if (ovb)
    );

    always #5 clk = ~clk;

    // Carrier generator: rf_i changes 2 ns after a posedge; per == 0 holds it low.
    initial begin
        rf_i = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (per == 0) begin
                rf_i = 1'b0;
                ph   = 0;
            end else begin
                if (ph == 0) begin
                    rf_i     = 1'b1;
                    rise_cyc = cyc;
                end else if (ph == per / 2) begin
                    rf_i = 1'b0;
                end
                ph = (ph + 1 >= per) ? 0 : ph + 1;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s (step %0d): observed %0d, expected %0d", tag, step, obs, exp);
        end
    endtask

    task automatic wait_dv(input bit sel_ov, input int maxc, output int at);
        int n;
        n  = 0;
        at = -1;
        while (n < maxc) begin
            @(posedge clk);
            #1;
            n++;
            if ((sel_ov ? ovb.data_valid_o : bus.data_valid_o) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        nvec++;
        assert (at >= 0) else begin
            nerr++;
            $error("FAIL strobe_wait (step %0d): observed none, expected strobe within %0d",
                   step, maxc);
        end
    endtask

    task automatic gate(input int cnt, input bit d);
        int at;
        step++;
        wait_dv(1'b0, cnt + 100, at);
        chk("gap", at - last, cnt);
        last = at;
        chk("period_count", int'(bus.period_count_o), cnt);
        chk("data", int'(bus.data_o), int'(d));
        chk("carrier", int'(bus.carrier_o), 1);
    endtask

    initial begin
        int lr;
        int at;
        int base;
        bit saw;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", int'(bus.data_o), 0);
        chk("rst_dv", int'(bus.data_valid_o), 0);
        chk("rst_count", int'(bus.period_count_o), 0);
        chk("rst_carrier", int'(bus.carrier_o), 0);
        chk("rst_ovf", int'(bus.overflow_o), 0);
        chk("rst_ov_ovf", int'(ovb.overflow_o), 0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Period 41: 656 per gate, data rises on the 2nd strobe.
        per = 41;
        #2;
        last = rise_cyc + 3;
        gate(656, 1'b0);
        @(posedge clk);
        #1;
        chk("dv_one_cycle", int'(bus.data_valid_o), 0);
        gate(656, 1'b1);

        // Lone 624 gate is filtered, and clears the confirm count.
        per = 39;
        gate(624, 1'b1);
        per = 41;
        gate(656, 1'b1);
        // Two 624 gates: data falls on the second one.
        per = 39;
        gate(624, 1'b1);
        gate(624, 1'b0);
        per = 41;
        gate(656, 1'b0);
        gate(656, 1'b1);

        // Dead band: count 640 never changes data.
        per = 40;
        repeat (4) gate(640, 1'b1);

        // Carrier loss: falls 1024 clk after the last acted-on edge, no strobe.
        step++;
        per = 0;
        lr  = rise_cyc;
        saw = 1'b0;
        do begin
            @(posedge clk);
            #1;
            saw |= bus.data_valid_o;
        end while (cyc != lr + 3 + 1023);
        chk("carrier_before_to", int'(bus.carrier_o), 1);
        @(posedge clk);
        #1;
        saw |= bus.data_valid_o;
        chk("carrier_after_to", int'(bus.carrier_o), 0);
        chk("no_strobe_to", int'(saw), 0);
        chk("data_hold_to", int'(bus.data_o), 1);
        chk("count_hold_to", int'(bus.period_count_o), 640);

        // Restart: strobe 16 periods after the first new edge.
        repeat (20) @(posedge clk);
        #1;
        per = 41;
        #2;
        last = rise_cyc + 3;
        gate(656, 1'b1);

        // Mid-gate reset.
        step++;
        repeat (300) @(posedge clk);
        #1;
        chk("ov_sticky", int'(ovb.overflow_o), 1);
        per   = 0;
        reset = 1'b1;
        #1;
        chk("mid_rst_data", int'(bus.data_o), 0);
        chk("mid_rst_count", int'(bus.period_count_o), 0);
        chk("mid_rst_carrier", int'(bus.carrier_o), 0);
        chk("mid_rst_dv", int'(bus.data_valid_o), 0);
        chk("mid_rst_ov_ovf", int'(ovb.overflow_o), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        per = 41;
        #2;
        last = rise_cyc + 3;
        base = last;
        gate(656, 1'b0);

        // Saturating instance: 32 x 41 = 1312 > 1023.
        step++;
        wait_dv(1'b1, 1400, at);
        chk("ov_gap", at - base, 1312);
        chk("ov_count", int'(ovb.period_count_o), 1023);
        chk("ov_flag", int'(ovb.overflow_o), 1);
        chk("ov_data_1st", int'(ovb.data_o), 0);
        chk("main_no_ovf", int'(bus.overflow_o), 0);
        base = at;
        wait_dv(1'b1, 1400, at);
        chk("ov_gap2", at - base, 1312);
        chk("ov_data_2nd", int'(ovb.data_o), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
